// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants used by the message schedule and the round core.
// The small-sigma amounts live here so the big-sigma constants can sit beside them.
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      ST_LOAD,
      ST_EMIT
   } sched_state_t;

   localparam int SHA256_BLOCK_WORDS = 16;
   localparam int SHA256_ROUNDS      = 64;

   localparam int SIG0_ROT_A = 7;
   localparam int SIG0_ROT_B = 18;
   localparam int SIG0_SHR   = 3;
   localparam int SIG1_ROT_A = 17;
   localparam int SIG1_ROT_B = 19;
   localparam int SIG1_SHR   = 10;

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Word-stream bundle between padder, message schedule and round core.
// Defining MSG_SCHED_IDX_OUT_EN adds out_idx carrying the schedule index t.
interface sha256_msg_sched_if;
   import sha256_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_data;
   logic  out_valid;
   logic  out_ready;
   word_t out_data;
   logic  out_last;
   logic  busy;
`ifdef MSG_SCHED_IDX_OUT_EN
   logic [5:0] out_idx;
`endif

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last,
`ifdef MSG_SCHED_IDX_OUT_EN
      output out_idx,
`endif
      output busy
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last,
`ifdef MSG_SCHED_IDX_OUT_EN
      input  out_idx,
`endif
      input  busy
   );

endinterface

// File: rtl/sha256_small_sigma.sv
// SHA-256 small-sigma word function: two rotates and one logical shift, XORed together.
module sha256_small_sigma
   import sha256_pkg::*;
#(
   parameter int ROT_A = SIG0_ROT_A,
   parameter int ROT_B = SIG0_ROT_B,
   parameter int SHR   = SIG0_SHR
) (
   input  word_t x,
   output word_t y
);

   assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, then streams W[0..63] from a 16-word ring.
// Optional macro MSG_SCHED_IDX_OUT_EN exposes the current index t on out_idx.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ROUNDS = SHA256_ROUNDS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sha256_msg_sched_if.slave    bus
);

   sched_state_t      state;
   logic [3:0]        cnt;
   logic [5:0]        t;
   logic [WORD_W-1:0] wbuf [SHA256_BLOCK_WORDS];
   logic              in_ready_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              busy_q;

   logic [3:0] t_lo;
   logic [3:0] idx2;
   logic [3:0] idx7;
   logic [3:0] idx15;
   word_t      s0;
   word_t      s1;
   word_t      new_w;
   logic       out_fire;

   // Ring-buffer taps: W[t-16] lives in the slot about to be overwritten with W[t].
   assign t_lo  = t[3:0];
   assign idx2  = t_lo - 4'd2;
   assign idx7  = t_lo - 4'd7;
   assign idx15 = t_lo - 4'd15;

   sha256_small_sigma #(
      .ROT_A (SIG0_ROT_A),
      .ROT_B (SIG0_ROT_B),
      .SHR   (SIG0_SHR)
   ) u_sig0 (
      .x (wbuf[idx15]),
      .y (s0)
   );

   sha256_small_sigma #(
      .ROT_A (SIG1_ROT_A),
      .ROT_B (SIG1_ROT_B),
      .SHR   (SIG1_SHR)
   ) u_sig1 (
      .x (wbuf[idx2]),
      .y (s1)
   );

   assign new_w    = s1 + wbuf[idx7] + s0 + wbuf[t_lo];
   assign out_fire = out_valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_LOAD;
         cnt         <= '0;
         t           <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < SHA256_BLOCK_WORDS; i++) begin
            wbuf[i] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (bus.in_valid && in_ready_q) begin
                  wbuf[cnt] <= bus.in_data;
                  cnt       <= cnt + 4'd1;
                  busy_q    <= 1'b1;
                  if (cnt == 4'd15) begin
                     state       <= ST_EMIT;
                     t           <= '0;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            ST_EMIT: begin
               if (out_fire) begin
                  if (t[5:4] != 2'b00) begin
                     wbuf[t_lo] <= new_w;
                  end
                  t          <= t + 6'd1;
                  out_last_q <= (t == 6'(ROUNDS - 2));
                  if (t == 6'(ROUNDS - 1)) begin
                     state       <= ST_LOAD;
                     cnt         <= '0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // The first 16 words pass straight out of the buffer; later ones are computed on the fly.
   assign bus.out_data  = (state == ST_EMIT) ? ((t[5:4] == 2'b00) ? wbuf[t_lo] : new_w) : '0;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
`ifdef MSG_SCHED_IDX_OUT_EN
   assign bus.out_idx   = t;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc", all-zero, stalls, junk input and mid-load reset.
// Build with MSG_SCHED_IDX_OUT_EN defined to also check out_idx.
module tb_sha256_msg_sched;
   import sha256_pkg::*;

   typedef word_t blk_t [16];
   typedef word_t sched_t [64];

   logic clk;
   logic rst_n;
   int   vectorCount;
   int   failCount;
   word_t got [64];

   sha256_msg_sched_if bus ();

   sha256_msg_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic word_t bsig0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic word_t bsig1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Plain 64-entry textbook schedule used as the expected stream.
   function automatic void refSchedule(input blk_t m, output sched_t w);
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = m[i];
         else        w[i] = bsig1(w[i-2]) + w[i-7] + bsig0(w[i-15]) + w[i-16];
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
      end
   endtask

   // Presents n words of m; waits for in_ready on each, bounded.
   task automatic applyStimulus(input blk_t m, input int n);
      int waitCycles;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = m[i];
         waitCycles   = 0;
         while (!bus.in_ready && waitCycles < 200) begin
            @(posedge clk); #1;
            waitCycles++;
         end
         if (waitCycles >= 200) checkOutput("load_timeout", 32'(i), 32'(n));
         @(posedge clk); #1;
         if (i == 0) checkOutput("busy_after_first", 32'(bus.busy), 32'd1);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      if (n == 16) begin
         checkOutput("out_valid_after_load", 32'(bus.out_valid), 32'd1);
         checkOutput("in_ready_after_load", 32'(bus.in_ready), 32'd0);
      end
   endtask

   // Collects the 64 schedule words, checking data every cycle (stalls included).
   task automatic drainBlock(input sched_t expW, input bit randomReady, input bit junkIn);
      int  idx;
      int  cycles;
      bit  rdy;
      idx    = 0;
      cycles = 0;
      while (idx < 64 && cycles < 3000) begin
         rdy = randomReady ? bit'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         if (junkIn) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
         end
         checkOutput($sformatf("out_valid_t%0d", idx), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("in_ready_t%0d", idx), 32'(bus.in_ready), 32'd0);
         checkOutput($sformatf("W%0d", idx), bus.out_data, expW[idx]);
`ifdef MSG_SCHED_IDX_OUT_EN
         checkOutput($sformatf("out_idx_t%0d", idx), 32'(bus.out_idx), 32'(idx));
`endif
         if (rdy && bus.out_valid) begin
            checkOutput($sformatf("out_last_t%0d", idx), 32'(bus.out_last), 32'(idx == 63));
            got[idx] = bus.out_data;
            idx++;
         end
         @(posedge clk); #1;
         cycles++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      checkOutput("handshakes", 32'(idx), 32'd64);
      checkOutput("busy_after_last", 32'(bus.busy), 32'd0);
      checkOutput("in_ready_after_last", 32'(bus.in_ready), 32'd1);
      checkOutput("out_valid_after_last", 32'(bus.out_valid), 32'd0);
      checkOutput("out_last_after_last", 32'(bus.out_last), 32'd0);
   endtask

   task automatic checkResetState();
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_out_data", bus.out_data, 32'd0);
`ifdef MSG_SCHED_IDX_OUT_EN
      checkOutput("rst_out_idx", 32'(bus.out_idx), 32'd0);
`endif
   endtask

   task automatic checkAbc(input string pfx);
      checkOutput({pfx, "_W0"},  got[0],  32'h61626380);
      checkOutput({pfx, "_W15"}, got[15], 32'h00000018);
      checkOutput({pfx, "_W16"}, got[16], 32'h61626380);
      checkOutput({pfx, "_W17"}, got[17], 32'h000F0000);
      checkOutput({pfx, "_W18"}, got[18], 32'h7DA86405);
      checkOutput({pfx, "_W63"}, got[63], 32'h12B1EDEB);
   endtask

   initial begin
      blk_t   abcBlk;
      blk_t   zeroBlk;
      blk_t   junkBlk;
      sched_t abcW;
      sched_t zeroW;

      vectorCount   = 0;
      failCount     = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      for (int i = 0; i < 16; i++) begin
         abcBlk[i]  = '0;
         zeroBlk[i] = '0;
         junkBlk[i] = 32'hA5A5_0000 + 32'(i * 32'h1357);
      end
      abcBlk[0]  = 32'h61626380;
      abcBlk[15] = 32'h00000018;
      refSchedule(abcBlk, abcW);
      refSchedule(zeroBlk, zeroW);

      repeat (3) @(posedge clk);
      #1;
      checkResetState();
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] abc block, out_ready high");
      applyStimulus(abcBlk, 16);
      drainBlock(abcW, 1'b0, 1'b0);
      checkAbc("abc");

      $display("[TB] abc block, out_ready toggling");
      applyStimulus(abcBlk, 16);
      drainBlock(abcW, 1'b1, 1'b0);
      checkAbc("abc_stall");

      $display("[TB] abc block, junk in_valid during emit");
      applyStimulus(abcBlk, 16);
      drainBlock(abcW, 1'b1, 1'b1);
      checkAbc("abc_junk");

      $display("[TB] all-zero block");
      applyStimulus(zeroBlk, 16);
      drainBlock(zeroW, 1'b0, 1'b0);

      $display("[TB] reset after 8 words, then abc block");
      applyStimulus(junkBlk, 8);
      rst_n = 1'b0;
      #3;
      checkResetState();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkResetState();
      applyStimulus(abcBlk, 16);
      drainBlock(abcW, 1'b0, 1'b0);
      checkAbc("abc_after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
